i2s_rx_capture: RTL and testbench

Receives stereo audio from the codec ADC over the Arduino-header I2S pins and presents each completed left/right sample pair to fabric logic through a valid/ready handshake. The codec is the I2S master and drives SCLK and LRCLK. This block only samples those clocks and the serial data line, with MAX10_CLK1_50 as the oversampling clock. It is the capture-direction counterpart of the playback serializer. It sits between the header pins and the record path that writes samples into SDRAM through the Avalon bridge.

---
 rtl/i2s_rx_capture_if.sv | 24 ++
 rtl/i2s_rx_capture.sv | 169 ++++++++++++++++
 tb/tb_i2s_rx_capture.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/i2s_rx_capture_if.sv
// Frame handshake bundle between the I2S capture block and the record path.
// The master presents a left/right sample pair; the slave accepts it with ready.
interface i2s_rx_capture_if #(
  parameter int W = 16
);
  logic [W-1:0] l_data;
  logic [W-1:0] r_data;
  logic         valid;
  logic         ready;

  modport master (
    output l_data,
    output r_data,
    output valid,
    input  ready
  );

  modport slave (
    input  l_data,
    input  r_data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/i2s_rx_capture.sv
// I2S slave-side capture: oversamples codec SCLK/LRCLK/SDIN on MAX10_CLK1_50
// and presents each completed left/right pair through a valid/ready handshake.
module i2s_rx_capture #(
  parameter int SAMPLE_W    = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic MAX10_CLK1_50,
  input  logic reset_n,
  input  logic enable,
  input  logic sclk_in,
  input  logic lrclk_in,
  input  logic sdin,
  input  logic clr_ovr,
  output logic overrun,
  i2s_rx_capture_if.master frm
);

  localparam int CW = $clog2(SAMPLE_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUN
  } state_t;

  logic [SYNC_STAGES-1:0] sclk_sync;
  logic [SYNC_STAGES-1:0] lr_sync;
  logic [SYNC_STAGES-1:0] sd_sync;
  logic                   sclk_hist;

  logic                sclk_s;
  logic                lr_s;
  logic                sd_s;
  logic                sre;
  logic                bnd;

  logic                lr_prev;
  logic [CW-1:0]       bcnt;
  logic [SAMPLE_W-1:0] shreg;
  logic [SAMPLE_W-1:0] left_hold;
  logic                have_left;
  state_t              state;

  logic [CW-1:0]       pad;
  logic [SAMPLE_W-1:0] word;
  logic                commit;
  logic                frame_new;
  logic                xfer;

  logic [SAMPLE_W-1:0] l_q;
  logic [SAMPLE_W-1:0] r_q;
  logic                valid_q;
  logic                ovr_q;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign lr_s   = lr_sync[SYNC_STAGES-1];
  assign sd_s   = sd_sync[SYNC_STAGES-1];
  assign sre    = sclk_s & ~sclk_hist;
  assign bnd    = sre & (lr_s != lr_prev);

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync <= '0;
      lr_sync   <= '0;
      sd_sync   <= '0;
      sclk_hist <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_in};
      lr_sync   <= {lr_sync[SYNC_STAGES-2:0], lrclk_in};
      sd_sync   <= {sd_sync[SYNC_STAGES-2:0], sdin};
      sclk_hist <= sclk_s;
    end
  end

  // Short slots leave the captured bits left-aligned with zero LSBs.
  always_comb begin
    pad       = CW'(SAMPLE_W) - bcnt;
    word      = shreg << pad;
    commit    = bnd & (state == RUN);
    frame_new = commit & lr_prev & have_left;
    xfer      = valid_q & frm.ready;
  end

  // The boundary edge carries the previous slot's LSB, so its data is dropped.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev <= 1'b0;
      bcnt    <= '0;
      shreg   <= '0;
    end else if (sre) begin
      lr_prev <= lr_s;
      if (lr_s != lr_prev) begin
        bcnt  <= '0;
        shreg <= '0;
      end else if (bcnt < CW'(SAMPLE_W)) begin
        shreg <= {shreg[SAMPLE_W-2:0], sd_s};
        bcnt  <= bcnt + 1'b1;
      end
    end
  end

  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      have_left <= 1'b0;
      left_hold <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (enable)
            state <= ARMED;
        end
        ARMED: begin
          if (!enable)
            state <= IDLE;
          else if (bnd & lr_prev & ~lr_s)
            state <= RUN;
        end
        RUN: begin
          if (!enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (!enable) begin
        have_left <= 1'b0;
      end else if (commit) begin
        if (!lr_prev) begin
          left_hold <= word;
          have_left <= 1'b1;
        end else if (have_left) begin
          have_left <= 1'b0;
        end
      end
    end
  end

  // Single frame register; a frame forming while one is stuck is dropped.
  always_ff @(posedge MAX10_CLK1_50 or negedge reset_n) begin
    if (!reset_n) begin
      l_q     <= '0;
      r_q     <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      if (frame_new) begin
        if (!valid_q || xfer) begin
          l_q     <= left_hold;
          r_q     <= word;
          valid_q <= 1'b1;
        end
      end else if (xfer) begin
        valid_q <= 1'b0;
      end

      if (frame_new & valid_q & ~xfer)
        ovr_q <= 1'b1;
      else if (clr_ovr)
        ovr_q <= 1'b0;
    end
  end

  assign frm.l_data = l_q;
  assign frm.r_data = r_q;
  assign frm.valid  = valid_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_i2s_rx_capture.sv
// Scoreboard bench for i2s_rx_capture: drives an I2S bit stream and
// compares every accepted frame against queued expectations.
`timescale 1ns/1ps
module tb_i2s_rx_capture;

  logic clk;
  logic reset_n;
  logic enable;
  logic sclk;
  logic lrclk;
  logic sdin;
  logic clr_ovr;
  logic overrun;

  i2s_rx_capture_if #(.W(16)) bus ();

  i2s_rx_capture #(
    .SAMPLE_W    (16),
    .SYNC_STAGES (2)
  ) dut (
    .MAX10_CLK1_50 (clk),
    .reset_n       (reset_n),
    .enable        (enable),
    .sclk_in       (sclk),
    .lrclk_in      (lrclk),
    .sdin          (sdin),
    .clr_ovr       (clr_ovr),
    .overrun       (overrun),
    .frm           (bus.master)
  );

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic carry = 1'b0;
  bit   sim_rdy = 1'b0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic bit_at(input logic [15:0] w, input int i);
    if (i >= 0 && i < 16)
      return w[15-i];
    return 1'b0;
  endfunction

  // One delay slot eats an SCLK, so a slot of len clocks yields len-1 bits.
  function automatic logic [15:0] exp_word(input logic [15:0] w, input int len);
    int nb;
    logic [31:0] m;
    nb = (len - 1 > 16) ? 16 : len - 1;
    m  = 32'hFFFF << (16 - nb);
    return w & m[15:0];
  endfunction

  task automatic push(input logic [15:0] l, input logic [15:0] r, input int len);
    exp_q.push_back({exp_word(l, len), exp_word(r, len)});
  endtask

  task automatic send_slot(input bit lr, input logic [15:0] w, input int len,
                           input bit lat, input int en_at, input int rst_at);
    for (int j = 0; j < len; j++) begin
      sclk  = 1'b0;
      lrclk = lr;
      sdin  = (j == 0) ? carry : bit_at(w, j - 1);
      if (j == en_at)
        enable = 1'b1;
      if (j == rst_at) begin
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_valid", {31'd0, bus.valid}, 32'd0);
        check("rst_ovr", {31'd0, overrun}, 32'd0);
        check("rst_l", {16'd0, bus.l_data}, 32'd0);
        check("rst_r", {16'd0, bus.r_data}, 32'd0);
        @(posedge clk); #2;
        reset_n = 1'b1;
        repeat (7) @(posedge clk);
        #2;
      end else begin
        repeat (8) @(posedge clk);
        #2;
      end
      sclk = 1'b1;
      if (j == 0) begin
        @(posedge clk);
        @(posedge clk); #2;
        if (sim_rdy)
          bus.ready = 1'b1;
        @(negedge clk);
        if (lat) check("lat_pre", {31'd0, bus.valid}, 32'd0);
        @(negedge clk);
        if (lat) check("lat_vld", {31'd0, bus.valid}, 32'd1);
        repeat (5) @(posedge clk);
        #2;
      end else begin
        repeat (8) @(posedge clk);
        #2;
      end
    end
    carry = bit_at(w, len - 1);
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.valid && bus.ready) begin
      if (exp_q.size() == 0) begin
        check("frame_q", 32'(exp_q.size()), 32'd1);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        check("frame_l", {16'd0, bus.l_data}, {16'd0, e[31:16]});
        check("frame_r", {16'd0, bus.r_data}, {16'd0, e[15:0]});
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n   = 1'b0;
    enable    = 1'b0;
    sclk      = 1'b0;
    lrclk     = 1'b0;
    sdin      = 1'b0;
    clr_ovr   = 1'b0;
    bus.ready = 1'b1;
    repeat (4) @(negedge clk);
    check("init_valid", {31'd0, bus.valid}, 32'd0);
    check("init_ovr", {31'd0, overrun}, 32'd0);
    check("init_l", {16'd0, bus.l_data}, 32'd0);
    check("init_r", {16'd0, bus.r_data}, 32'd0);
    @(posedge clk); #2;
    reset_n = 1'b1;
    enable  = 1'b1;
    repeat (3) @(posedge clk);
    #2;

    // basic capture
    send_slot(1'b1, 16'hFFFF, 32, 1'b0, -1, -1);
    for (int k = 0; k < 4; k++) begin
      send_slot(1'b0, 16'hA5C3, 32, k != 0, -1, -1);
      send_slot(1'b1, 16'h3C5A, 32, 1'b0, -1, -1);
      push(16'hA5C3, 16'h3C5A, 32);
    end

    // back-pressure
    send_slot(1'b0, 16'h1111, 32, 1'b1, -1, -1);
    bus.ready = 1'b0;
    send_slot(1'b1, 16'h2222, 32, 1'b0, -1, -1);
    push(16'h1111, 16'h2222, 32);
    send_slot(1'b0, 16'h3333, 32, 1'b0, -1, -1);
    send_slot(1'b1, 16'h4444, 32, 1'b0, -1, -1);
    send_slot(1'b0, 16'h5555, 32, 1'b0, -1, -1);
    @(negedge clk);
    check("bp_valid", {31'd0, bus.valid}, 32'd1);
    check("bp_l", {16'd0, bus.l_data}, 32'h1111);
    check("bp_r", {16'd0, bus.r_data}, 32'h2222);
    check("bp_ovr", {31'd0, overrun}, 32'd1);
    @(posedge clk); #2;
    clr_ovr = 1'b1;
    @(posedge clk); #2;
    clr_ovr = 1'b0;
    @(negedge clk);
    check("ovr_clr", {31'd0, overrun}, 32'd0);
    @(posedge clk); #2;
    bus.ready = 1'b1;
    send_slot(1'b1, 16'h6666, 32, 1'b0, -1, -1);
    push(16'h5555, 16'h6666, 32);

    // short slot
    send_slot(1'b0, 16'hABC0, 12, 1'b0, -1, -1);
    send_slot(1'b1, 16'h0123, 12, 1'b0, -1, -1);
    push(16'hABC0, 16'h0123, 12);

    // simultaneous accept and new frame
    bus.ready = 1'b0;
    send_slot(1'b0, 16'h7777, 32, 1'b0, -1, -1);
    check("short_l", {16'd0, bus.l_data}, 32'hABC0);
    send_slot(1'b1, 16'h8888, 32, 1'b0, -1, -1);
    push(16'h7777, 16'h8888, 32);
    sim_rdy = 1'b1;
    send_slot(1'b0, 16'h1234, 32, 1'b0, -1, -1);
    sim_rdy = 1'b0;
    check("sim_ovr", {31'd0, overrun}, 32'd0);

    // arming mid left slot
    enable = 1'b0;
    send_slot(1'b1, 16'h5678, 32, 1'b0, -1, -1);
    send_slot(1'b0, 16'hAAAA, 32, 1'b0, 10, -1);
    send_slot(1'b1, 16'hBBBB, 32, 1'b0, -1, -1);
    send_slot(1'b0, 16'hCCCC, 32, 1'b0, -1, -1);
    send_slot(1'b1, 16'hDDDD, 32, 1'b0, -1, -1);
    push(16'hCCCC, 16'hDDDD, 32);
    send_slot(1'b0, 16'hEEEE, 32, 1'b1, -1, -1);

    // reset during right-slot bit 7
    send_slot(1'b1, 16'h0F0F, 32, 1'b0, -1, 8);
    send_slot(1'b0, 16'h1357, 32, 1'b0, -1, -1);
    send_slot(1'b1, 16'h2468, 32, 1'b0, -1, -1);
    push(16'h1357, 16'h2468, 32);
    send_slot(1'b0, 16'h0000, 32, 1'b1, -1, -1);

    repeat (20) @(negedge clk);
    check("q_empty", 32'(exp_q.size()), 32'd0);
    check("end_ovr", {31'd0, overrun}, 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
